spi_controller: RTL and testbench

- SPI mode-0 controller (initiator) that turns single-cycle register commands on the `clk` domain into 16-bit frames on `SCLK`/`nCS`/`COPI`.
- Drives the on-chip SPI register-file peripheral (PWM/output-enable registers) from a test or host sequencer.
- Frame format: bit15 = write flag (1 = write, 0 = read), bits14:8 = address, bits7:0 = data. MSB first.
- Optionally captures `CIPO` during the data byte of read frames.

---
 rtl/spi_controller.sv | 173 +++++++++++++++++
 tb/tb_spi_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator. Turns single-cycle register commands
// into 16-bit frames {write, addr[6:0], data[7:0]}, sent MSB first, and
// captures CIPO during the data byte of read frames.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write/addr/wdata command fields (wdata is sent as 0x00 on reads)
//   rsp_valid            one-cycle pulse on the first cycle after nCS rises
//   rsp_rdata            CIPO byte from the last read frame
//   busy                 frame in progress (inverse of cmd_ready)
//   SCLK, nCS, COPI      serial outputs, all driven directly from flops
//   CIPO                 serial input
//
// Timing notes:
//   SETUP    nCS low, SCLK low, COPI = bit 15, for CS_SETUP cycles.
//   HIGH/LOW CLK_DIV cycles each, once per bit plus EXTRA_EDGES trailing
//            pulses. COPI advances on entry to LOW, so it never moves while
//            SCLK is high. Trailing pulses carry zeros shifted in behind
//            bit 0.
//   HOLD     CS_HOLD cycles with SCLK low before nCS rises.
//   GAP      IDLE_GAP cycles with nCS high, then back to IDLE.
//   CS_HOLD and IDLE_GAP must be at least 1.
module spi_controller #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 4,
  parameter int unsigned IDLE_GAP    = 4,
  parameter int unsigned EXTRA_EDGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'(15 + EXTRA_EDGES);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(IDLE_GAP - 1);

  state_t      state, state_n;
  logic [7:0]  ph, ph_n;          // phase counter: counts down, reloaded on each state change
  logic [4:0]  bit_cnt, bit_n;    // SCLK pulse index within the frame
  logic [15:0] sh, sh_n;          // outgoing frame; sh[15] is the bit on the wire
  logic [7:0]  rx, rx_n;          // incoming data byte, copied out at frame end
  logic        is_read, rd_n;
  logic        sclk_n, ncs_n, copi_n, rv_n;
  logic [7:0]  rdata_n;
  logic        ph_done;

  assign ph_done   = (ph == 8'd0);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ph        <= 8'd0;
      bit_cnt   <= 5'd0;
      sh        <= 16'h0000;
      rx        <= 8'h00;
      is_read   <= 1'b0;
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      bit_cnt   <= bit_n;
      sh        <= sh_n;
      rx        <= rx_n;
      is_read   <= rd_n;
      SCLK      <= sclk_n;
      nCS       <= ncs_n;
      COPI      <= copi_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rdata_n;
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph_done ? 8'd0 : ph - 8'd1;
    bit_n   = bit_cnt;
    sh_n    = sh;
    rx_n    = rx;
    rd_n    = is_read;
    sclk_n  = SCLK;
    ncs_n   = nCS;
    copi_n  = COPI;
    rv_n    = 1'b0;
    rdata_n = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_n = S_SETUP;
          ph_n    = SETUP_LD;
          bit_n   = 5'd0;
          sh_n    = {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 8'h00};
          rd_n    = ~cmd_write;
          ncs_n   = 1'b0;
          sclk_n  = 1'b0;
          copi_n  = cmd_write;   // frame bit 15
        end
      end
      S_SETUP: begin
        if (ph_done) begin
          state_n = S_HIGH;
          ph_n    = DIV_LD;
          sclk_n  = 1'b1;
        end
      end
      S_HIGH: begin
        if (ph_done) begin
          state_n = S_LOW;
          ph_n    = DIV_LD;
          sclk_n  = 1'b0;
          sh_n    = {sh[14:0], 1'b0};
          copi_n  = sh[14];
          // last HIGH cycle of pulses 8..15 carries data bits 7..0
          if (is_read && bit_cnt >= 5'd8 && bit_cnt <= 5'd15)
            rx_n = {rx[6:0], CIPO};
        end
      end
      S_LOW: begin
        if (ph_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_n = S_HOLD;
            ph_n    = HOLD_LD;
          end else begin
            state_n = S_HIGH;
            ph_n    = DIV_LD;
            bit_n   = bit_cnt + 5'd1;
            sclk_n  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (ph_done) begin
          state_n = S_GAP;
          ph_n    = GAP_LD;
          ncs_n   = 1'b1;
          copi_n  = 1'b0;
          rv_n    = 1'b1;
          if (is_read) rdata_n = rx;
        end
      end
      S_GAP: begin
        if (ph_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller. Commands are pushed into a scoreboard on accept;
// a line monitor rebuilds each frame from the pins (COPI bits at SCLK rises,
// pulse count, nCS width, phase widths) and pops/compares, and a response
// monitor checks rsp_rdata on every rsp_valid pulse. The monitor also plays
// the peripheral's CIPO side, returning a chosen byte on pulses 8..15.
module tb_spi_controller;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int IDLE_GAP = 4;
  localparam int EXTRA    = 1;
  localparam int NCS_LOW  = CS_SETUP + (16 + EXTRA) * 2 * CLK_DIV + CS_HOLD;
  localparam int ACC_GAP  = 1 + NCS_LOW + IDLE_GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid, busy, SCLK, nCS, COPI;
  logic [7:0] rsp_rdata;
  logic       CIPO = 1'b0;

  spi_controller #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
    .IDLE_GAP(IDLE_GAP), .EXTRA_EDGES(EXTRA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SCLK(SCLK), .nCS(nCS), .COPI(COPI), .CIPO(CIPO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_frame[$];
  logic [7:0]  q_rsp[$];
  logic [7:0]  q_cipo[$];
  logic [7:0]  last_rd = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic cipo_bit(input int k, input logic [7:0] rb);
    if (k >= 8 && k <= 15) return rb[15 - k];
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- line monitor ----------------
  bit          in_frame = 0, have_prev = 0, perr = 0, copi_err = 0;
  int          edges = 0, low_cnt = 0, hi_cnt = 0, run = 0;
  logic [31:0] bits = '0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  logic [7:0]  cur_rb = '0;
  logic [15:0] exp_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; have_prev = 0; hi_cnt = 0;
      prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
    end else begin
      if (prev_ncs && !nCS) begin
        if (have_prev) chk("idle_gap_min", 32'(hi_cnt >= IDLE_GAP), 1);
        in_frame = 1; edges = 0; low_cnt = 1; run = 1; bits = '0;
        perr = (SCLK !== 1'b0); copi_err = 0;
        cur_rb = 8'h00;
        if (q_cipo.size() > 0) cur_rb = q_cipo.pop_front();
        CIPO = cipo_bit(0, cur_rb);
      end else if (!prev_ncs && nCS && in_frame) begin
        if (run != CLK_DIV + CS_HOLD || prev_sclk) perr = 1;
        in_frame = 0; have_prev = 1; hi_cnt = 1;
        if (q_frame.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: frame of %0d pulses with no pending command", edges);
        end else begin
          exp_f = q_frame.pop_front();
          chk("copi_frame", bits[16:0], {exp_f, 1'b0});
        end
        chk("sclk_rises", edges, 16 + EXTRA);
        chk("ncs_low_cycles", low_cnt, NCS_LOW);
        chk("phase_widths", perr, 0);
        chk("copi_stable_high", copi_err, 0);
        chk("rsp_at_cs_rise", rsp_valid, 1);
        chk("busy_in_gap", {busy, cmd_ready}, 2'b10);
        chk("idle_pins", {SCLK, COPI}, 0);
      end else if (in_frame) begin
        low_cnt++;
        if (SCLK && COPI !== prev_copi) copi_err = 1;
        if (SCLK === prev_sclk) run++;
        else begin
          if (prev_sclk) begin
            if (run != CLK_DIV) perr = 1;
            CIPO = cipo_bit(edges, cur_rb);
          end else begin
            if (run != ((edges == 0) ? CS_SETUP : CLK_DIV)) perr = 1;
            edges++;
            bits = {bits[30:0], COPI};
          end
          run = 1;
        end
      end else if (nCS) hi_cnt++;
      prev_ncs = nCS; prev_sclk = SCLK; prev_copi = COPI;
    end
  end

  // ---------------- response monitor ----------------
  logic [7:0] exp_rd;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: rsp_valid with rdata 0x%0h and no pending command", rsp_rdata);
      end else begin
        exp_rd = q_rsp.pop_front();
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the accepting edge
  // with cmd_valid still high.
  task automatic send(input bit w, input logic [6:0] a, input logic [7:0] d,
                      input logic [7:0] rb, output int acc);
    int n = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready low for %0d cycles", n);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
    q_frame.push_back({w, a, w ? d : 8'h00});
    q_cipo.push_back(rb);
    if (!w) last_rd = rb;
    q_rsp.push_back(last_rd);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_frame.size() != 0 || q_rsp.size() != 0 || !cmd_ready) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d frames, %0d responses outstanding", q_frame.size(), q_rsp.size());
    end
  endtask

  initial begin
    int a0, a1, n;
    repeat (3) @(negedge clk);
    chk("rst_sclk", SCLK, 0);
    chk("rst_ncs", nCS, 1);
    chk("rst_copi", COPI, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // single write 0x04 <= 0x80 (frame 0x8480)
    send(1'b1, 7'h04, 8'h80, 8'($urandom), a0);
    cmd_valid = 1'b0;
    drain();

    // back-to-back writes with cmd_valid held
    send(1'b1, 7'h00, 8'hF0, 8'($urandom), a0);
    send(1'b1, 7'h02, 8'h0F, 8'($urandom), a1);
    cmd_valid = 1'b0;
    chk("b2b_accept_spacing", a1 - a0, ACC_GAP);
    drain();

    // read 0x01, peripheral returns 0xA5; wdata must not reach the wire
    send(1'b0, 7'h01, 8'h3C, 8'hA5, a0);
    cmd_valid = 1'b0;
    drain();

    // command pulsed while busy is dropped; in-flight frame unaffected
    send(1'b1, 7'h05, 8'h77, 8'($urandom), a0);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // randomized mix, sometimes back-to-back
    for (int i = 0; i < 20; i++) begin
      int g;
      send(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), a0);
      g = $urandom_range(0, 3);
      if (g > 0) begin
        cmd_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    drain();

    // reset in the middle of a write to 0x03
    send(1'b1, 7'h03, 8'hC3, 8'($urandom), a0);
    cmd_valid = 1'b0;
    n = 0;
    while (!in_frame && n < 50) begin @(negedge clk); n++; end
    while (edges < 6 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL midframe_wait: only %0d SCLK rises seen", edges);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ncs", nCS, 1);
    chk("midrst_sclk", SCLK, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    q_frame.delete(); q_rsp.delete(); q_cipo.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 7'h03, 8'h55, 8'($urandom), a0);
    cmd_valid = 1'b0;
    drain();
    // a follow-up read confirms rsp_rdata restarted from its reset value path
    send(1'b0, 7'h03, 8'h00, 8'h5A, a0);
    cmd_valid = 1'b0;
    drain();

    chk("queues_empty", q_frame.size() + q_rsp.size() + q_cipo.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
